// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths and FIFO state type for the 8-to-3 encoder pipe
package enc_pkg;
  localparam int LINES_W = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;
endpackage

// File: rtl/pe8to3.sv
// rtl/pe8to3.sv - combinational priority encoder with one-hot violation flag
module pe8to3
  import enc_pkg::*;
(
  input  logic [LINES_W-1:0] lines,
  output logic [CODE_W-1:0]  code,
  output logic               err
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < LINES_W; i++) begin
      if (lines[i]) code = CODE_W'(i);
    end
  end

  assign err = (lines == '0) || ((lines & (lines - 1'b1)) != '0);

endmodule

// File: rtl/enc8to3_pipe.sv
// rtl/enc8to3_pipe.sv - priority encoder feeding a 2-entry output FIFO with error counter
module enc8to3_pipe
  import enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LINES_W-1:0]   in_lines,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CODE_W-1:0]    out_code,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count
);

  fifo_state_e       state, state_next;
  logic [CODE_W-1:0] pe_code;
  logic              pe_err;
  logic [CODE_W-1:0] head_code, tail_code;
  logic              head_err, tail_err;
  logic              push, pop;

  pe8to3 u_pe (
    .lines (in_lines),
    .code  (pe_code),
    .err   (pe_err)
  );

  // Both handshake outputs decode the registered state only.
  assign in_ready  = (state != FIFO_TWO);
  assign out_valid = (state != FIFO_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_code  = head_code;
  assign out_err   = head_err;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FIFO_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FIFO_EMPTY: if (push) state_next = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_next = FIFO_TWO;
        else if (pop && !push) state_next = FIFO_EMPTY;
      end
      FIFO_TWO:   if (pop) state_next = FIFO_ONE;
      default:    state_next = FIFO_EMPTY;
    endcase
  end

  // Head always holds the oldest entry, so it only moves on a pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_code <= '0;
      head_err  <= 1'b0;
      tail_code <= '0;
      tail_err  <= 1'b0;
    end else begin
      case (state)
        FIFO_EMPTY: begin
          if (push) begin
            head_code <= pe_code;
            head_err  <= pe_err;
          end
        end
        FIFO_ONE: begin
          if (push && pop) begin
            head_code <= pe_code;
            head_err  <= pe_err;
          end else if (push) begin
            tail_code <= pe_code;
            tail_err  <= pe_err;
          end
        end
        FIFO_TWO: begin
          if (pop) begin
            head_code <= tail_code;
            head_err  <= tail_err;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (push && pe_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_enc8to3_pipe.sv
// tb/tb_enc8to3_pipe.sv - scoreboard bench for enc8to3_pipe
module tb_enc8to3_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_lines = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_err, out_valid;
  logic [2:0] out_code;
  logic [7:0] err_count;
  logic       s_in_ready, s_out_err, s_out_valid;
  logic [2:0] s_out_code;
  logic [1:0] s_err_count;

  enc8to3_pipe #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_lines(in_lines), .in_valid(in_valid),
    .in_ready(in_ready), .out_code(out_code), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  enc8to3_pipe #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_lines(in_lines), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_code(s_out_code), .out_err(s_out_err),
    .out_valid(s_out_valid), .out_ready(out_ready), .err_count(s_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  int   exp_cnt = 0;
  int   exp_cnt_s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Highest set bit from log2, one-hot test from the population count.
  function automatic exp_t model(input logic [7:0] v, input int c);
    exp_t e;
    e.code = (v == 8'h00) ? 3'd0 : 3'($clog2(int'(v) + 1) - 1);
    e.err  = ($countones(v) != 1);
    e.cyc  = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs are set before the call; one clock edge is consumed.
  task automatic step();
    logic acc, acc_err;
    acc = 1'b0;
    acc_err = 1'b0;
    #1;
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(in_lines, cyc));
      acc = 1'b1;
      acc_err = ($countones(in_lines) != 1);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
      exp_cnt_s = 0;
    end else if (acc && acc_err) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt_s < 3) exp_cnt_s++;
    end
    check("err_count", err_count, exp_cnt);
    check("err_count_sat", s_err_count, exp_cnt_s);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_code", out_code, 3'd0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_sat_out_valid", s_out_valid, 1'b0);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the presented head every cycle, pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = sb[0];
          check("out_code", out_code, e.code);
          check("out_err", out_err, e.err);
          check("sat_out_code", s_out_code, e.code);
          if (out_ready) begin
            void'(sb.pop_front());
            if (lat_chk) check("latency", cyc - e.cyc, 1);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] errv[3];
    int sat_seq[5];
    logic [7:0] v;
    errv = '{8'h00, 8'hA4, 8'h06};
    sat_seq = '{1, 2, 3, 3, 3};

    @(negedge clk);
    do_reset();

    lat_chk = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_lines = 8'(1 << i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      in_lines = errv[i];
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("err_count_after_errs", err_count, 8'd3);

    lat_chk = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_lines = 8'h08;
    step();
    in_lines = 8'h10;
    step();
    check("in_ready_full", in_ready, 1'b0);
    in_lines = 8'h20;
    step();
    step();
    check("in_ready_still_full", in_ready, 1'b0);
    check("held_depth", sb.size(), 2);
    out_ready = 1'b1;
    step();
    check("in_ready_after_pop", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("bp_drained", sb.size(), 0);

    lat_chk = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_lines = 8'(1 << $urandom_range(7));
      step();
      check("in_ready_stream", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step();
    step();

    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom_range(255));
      while ($countones(v) == 1) v = 8'($urandom_range(255));
      in_valid = 1'b1;
      in_lines = v;
      step();
      check("sat_seq", s_err_count, sat_seq[i]);
    end
    in_valid = 1'b0;
    step();
    step();

    lat_chk = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_lines = 8'h01;
    step();
    in_lines = 8'h40;
    step();
    check("two_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    in_lines = 8'h00;
    do_reset();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_out_valid", out_valid, 1'b0);

    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      in_lines = ($urandom_range(1) != 0) ? 8'(1 << $urandom_range(7)) : 8'($urandom_range(255));
      step();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    step();
    check("final_drain", sb.size(), 0);
    check("final_out_valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
